// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch: FSM encoding, BCD width
// and active-low seven-segment patterns (bit order a..g, seg[0] = a).
package stopwatch_pkg;

  localparam int BCD_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_e;

  localparam logic [0:6] SEG_0     = 7'b0000001;
  localparam logic [0:6] SEG_1     = 7'b1001111;
  localparam logic [0:6] SEG_2     = 7'b0010010;
  localparam logic [0:6] SEG_3     = 7'b0000110;
  localparam logic [0:6] SEG_4     = 7'b1001100;
  localparam logic [0:6] SEG_5     = 7'b0100100;
  localparam logic [0:6] SEG_6     = 7'b0100000;
  localparam logic [0:6] SEG_7     = 7'b0001111;
  localparam logic [0:6] SEG_8     = 7'b0000000;
  localparam logic [0:6] SEG_9     = 7'b0000100;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  // Codes 10..15 cannot come out of the count chain; they decode as blank.
  function automatic logic [0:6] seg_decode(input logic [BCD_W-1:0] v);
    case (v)
      4'd0:    seg_decode = SEG_0;
      4'd1:    seg_decode = SEG_1;
      4'd2:    seg_decode = SEG_2;
      4'd3:    seg_decode = SEG_3;
      4'd4:    seg_decode = SEG_4;
      4'd5:    seg_decode = SEG_5;
      4'd6:    seg_decode = SEG_6;
      4'd7:    seg_decode = SEG_7;
      4'd8:    seg_decode = SEG_8;
      4'd9:    seg_decode = SEG_9;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/stopwatch_core_sevenseg_scan.sv
// Multiplexed seven-segment scanner: scan counter, digit select, decode and
// registered outputs. STOPWATCH_BLANK_EN enables leading-zero blanking.
module sevenseg_scan
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int SCAN_DIV   = 1,
  parameter int DP_POS     = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NUM_DIGITS*BCD_W-1:0]  bcd_i,
  output logic [0:6]                   seg_o,
  output logic                         dp_o,
  output logic [NUM_DIGITS-1:0]        digit_o
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [DW-1:0]         div_q, div_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [0:6]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] digit_q, digit_d;
  logic [NUM_DIGITS-1:0] blank;
  logic [BCD_W-1:0]      cur;

`ifdef STOPWATCH_BLANK_EN
  // A digit above the decimal point blanks when it and every digit above it are zero.
  always_comb begin : blank_gen
    logic zero_above;
    blank      = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i > DP_POS; i--) begin
      zero_above = zero_above && (bcd_i[i*BCD_W +: BCD_W] == '0);
      blank[i]   = zero_above;
    end
  end
`else
  assign blank = '0;
`endif

  assign cur = bcd_i[idx_q*BCD_W +: BCD_W];

  always_comb begin
    div_d = div_q;
    idx_d = idx_q;
    if (div_q == DW'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      div_d = div_q + 1'b1;
    end
    digit_d = blank[idx_q] ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    seg_d   = blank[idx_q] ? SEG_BLANK : seg_decode(cur);
    dp_d    = !(int'(idx_q) == DP_POS);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q   <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      digit_q <= '1;
    end else begin
      div_q   <= div_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      digit_q <= digit_d;
    end
  end

  assign seg_o   = seg_q;
  assign dp_o    = dp_q;
  assign digit_o = digit_q;

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch top: run/pause/lap/clear FSM, tick prescaler, BCD count chain and
// lap register. Define STOPWATCH_BLANK_EN for leading-zero blanking in the scanner.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int TICK_HZ    = 10,
  parameter int NUM_DIGITS = 8,
  parameter int REFRESH_HZ = 1000,
  parameter int DP_POS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_stop,
  input  logic                  lap,
  input  logic                  clear,
  output logic [0:6]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] digit,
  output logic                  running,
  output logic                  overflow
);

  localparam int DIV      = CLK_HZ / TICK_HZ;
  localparam int SCAN_DIV = CLK_HZ / REFRESH_HZ;
  localparam int PW       = $clog2(DIV);

  state_e                             state_q, state_d;
  logic [PW-1:0]                      pre_q, pre_d;
  logic [NUM_DIGITS-1:0][BCD_W-1:0]   cnt_q, cnt_d, lap_q, lap_d;
  logic                               ovf_q, ovf_d;
  logic                               show_lap, do_lap, do_clear;
  logic [NUM_DIGITS*BCD_W-1:0]        disp;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // start_stop outranks clear, clear outranks lap; losers are dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_stop) state_d = ST_RUN;
      ST_RUN,
      ST_LAP:   if (start_stop)          state_d = ST_PAUSE;
                else if (lap && !clear)  state_d = ST_LAP;
      ST_PAUSE: if (start_stop)          state_d = ST_RUN;
                else if (clear)          state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    running  = 1'b0;
    show_lap = 1'b0;
    do_lap   = 1'b0;
    do_clear = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        running = 1'b1;
        do_lap  = lap && !start_stop && !clear;
      end
      ST_LAP: begin
        running  = 1'b1;
        show_lap = 1'b1;
        do_lap   = lap && !start_stop && !clear;
      end
      ST_PAUSE: do_clear = clear && !start_stop;
      default: ;
    endcase
  end

  always_comb begin : datapath
    logic carry;
    pre_d = pre_q;
    cnt_d = cnt_q;
    lap_d = lap_q;
    ovf_d = ovf_q;
    carry = 1'b0;
    if (running) begin
      if (pre_q == PW'(DIV - 1)) begin
        pre_d = '0;
        carry = 1'b1;
      end else begin
        pre_d = pre_q + 1'b1;
      end
    end
    // Ripple the tick through every digit in the same cycle.
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (cnt_q[i] == 4'd9) begin
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
          carry    = 1'b0;
        end
      end
    end
    if (carry)  ovf_d = 1'b1;
    if (do_lap) lap_d = cnt_q;
    if (do_clear) begin
      pre_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
      cnt_q <= '0;
      lap_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
      lap_q <= lap_d;
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
  assign disp     = show_lap ? lap_q : cnt_q;

  sevenseg_scan #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV),
    .DP_POS     (DP_POS)
  ) u_scan (
    .clk_i   (clk),
    .rst_i   (rst),
    .bcd_i   (disp),
    .seg_o   (seg),
    .dp_o    (dp),
    .digit_o (digit)
  );

endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Parametrised stopwatch with run/pause/lap/clear control, a configurable-length BCD count chain and multiplexed seven-segment scan output. Sits between the board button conditioners and the seven-segment pins, and replaces the fixed four-digit, always-running stopwatch top. Adds:
- variable digit count and tick rate;
- start/stop, lap-freeze and clear;
- a sticky overflow flag.

## Interface
- CLK_HZ, 100_000_000: system clock frequency.
- TICK_HZ, 10: count rate. DIV = CLK_HZ/TICK_HZ; DIV must be an integer ≥ 2.
- NUM_DIGITS, 8: number of BCD digits, 1..8.
- REFRESH_HZ, 1000: digit-advance rate. SCAN_DIV = CLK_HZ/REFRESH_HZ, must be ≥ 1.
- DP_POS, 1: digit index whose decimal point is lit. Index 0 is least significant.
- clk in 1: system clock. One clock domain; all logic on its rising edge.
- rst in 1: synchronous, active-high reset.
- start_stop in 1: single-cycle pulse, already debounced.
- lap in 1: single-cycle pulse, already debounced.
- clear in 1: single-cycle pulse, already debounced.
- seg out [0:6]: segments a..g, active-low, registered.
- dp out 1: decimal point, active-low, registered.
- digit out [NUM_DIGITS-1:0]: anodes, active-low, one-hot-low, registered.
- running out 1: high in RUN and LAP.
- overflow out 1: sticky flag, set on count wrap.

## Operation
- States and transitions:
  - IDLE: start_stop → RUN. lap and clear are ignored.
  - RUN: start_stop → PAUSE. lap → LAP, capturing count into lap_reg. clear is ignored.
  - LAP: counting continues; the display shows lap_reg. lap → LAP, recapturing lap_reg. start_stop → PAUSE, display returns to live count.
  - PAUSE: start_stop → RUN. clear → IDLE.
- Leaving LAP: only via start_stop; a second lap press re-captures.
- clear in PAUSE: zeroes count, prescaler and overflow.
- Simultaneous pulses: priority is start_stop > clear > lap. Only the winner acts; the others are dropped.
- Prescaler: counts 0..DIV-1 only in RUN or LAP.
  - Holds its value in PAUSE, so resume keeps the partial tick.
  - Zeroed by rst and by clear.
- Count: NUM_DIGITS BCD digits, ripple carry within one cycle.
  - Increments when prescaler == DIV-1.
  - All digits at 9 plus a tick → all digits 0, overflow ← 1.
  - overflow clears only on rst or clear.
- Display source: lap_reg in LAP, live count otherwise.
- Scan: index 0..NUM_DIGITS-1, advances every SCAN_DIV cycles and wraps to 0. Runs in every state.
- Decimal point: dp = 0 exactly when the scan index == DP_POS.
- Segment patterns: standard 0–9 encodings. BCD values 10–15 never occur; decode them as all segments off.

## Timing
- Reset values:
  - seg = 7'b1111111, dp = 1, digit = all ones.
  - running = 0, overflow = 0.
  - state = IDLE, count = 0, lap_reg = 0, prescaler = 0, scan index = 0.
- Pulse sampled at edge n → new state, and running, visible from cycle n+1.
- lap_reg is captured at the same edge as the LAP transition.
- Tick timing: with prescaler == DIV-1 in cycle n, the new count is visible in cycle n+1.
- Display latency: seg, dp and digit lag the scan index and count by exactly 1 cycle (registered).
- rst mid-operation: all state returns to reset values at the next edge, overriding any pulse in that cycle.

## Configuration
- STOPWATCH_BLANK_EN defined: leading-zero blanking. Digits above DP_POS that are zero, with all higher digits also zero, have their anode held high. The digit at DP_POS and all below always display.
- STOPWATCH_BLANK_EN undefined: every digit displays, including leading zeros.

## Structure
- stopwatch_pkg holds:
  - the state encoding (IDLE, RUN, PAUSE, LAP);
  - the seven-segment pattern constants for 0–9 and blank;
  - the BCD width constant (4).
- Sub-module sevenseg_scan: scan counter, digit select, decode, dp and output registers.
  - Parameters: NUM_DIGITS, SCAN_DIV, DP_POS.
  - Input: packed BCD vector.
  - Contains the STOPWATCH_BLANK_EN logic.
- The top-level stopwatch_core holds the FSM, prescaler, BCD chain and lap_reg.

## Test plan
- Bench parameters: CLK_HZ=100, TICK_HZ=10 (DIV=10), REFRESH_HZ=50 (SCAN_DIV=2), NUM_DIGITS=4, DP_POS=1.
- Reset then idle: after 100 cycles count = 0000, running = 0. The digit pattern cycles 1110 → 1101 → 1011 → 0111 every 2 cycles; dp = 0 only with digit = 1101.
- start_stop, then 35 cycles, then start_stop: count = 0003, state = PAUSE. After a second start_stop the next tick lands 5 cycles later, proving the prescaler is held.
- Lap: run to 0012, pulse lap → displayed value frozen at 0012 while the internal count reaches 0020. start_stop → PAUSE, display shows the live count 0020.
- Overflow: force the count to 9999 in RUN; the next tick gives 0000 with overflow = 1. start_stop then clear → 0000, overflow = 0, state = IDLE.
- Simultaneous: start_stop, clear and lap in the same cycle while in PAUSE → RUN; count, overflow and lap_reg unchanged. rst asserted during RUN → all reset values on the next cycle.
- With STOPWATCH_BLANK_EN and count 0005: digit anodes 3 and 2 stay high, digits 1 and 0 display "0." and "5".
